vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
Master raster sequencer for the 640x480@60 Hz VGA output path. Divides the 100 MHz system clock into a pixel-rate tick, runs the horizontal (0..799) and vertical (0..524) counters, and issues the line-advance strobe that steps the vertical count. It also decodes active-low hsync/vsync, video_on and a frame-start pulse for the pixel generator and game-logic frame update.

Parameters:
CLK_DIV, 4, system clocks per pixel (pixel tick period); legal range 2..16
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
en  in  1  run enable; low freezes divider and both counters
pix_tick  out  1  one-clk pulse once per pixel period
line_adv  out  1  one-clk pulse, coincident with pix_tick, when H counter wraps (vertical enable)
pixel_x  out  10  horizontal count, 0..H_TOTAL-1
pixel_y  out  10  vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
video_on  out  1  high while pixel is in the visible region
frame_start  out  1  one-clk pulse when raster wraps to (0,0)

Behaviour:
- Reset (rst=1 at posedge): divider=0, pixel_x=0, pixel_y=0, pix_tick=0, line_adv=0, frame_start=0, hsync=1, vsync=1, video_on=0. rst has priority over en.
- Divider: counts 0..CLK_DIV-1 on clocks where en=1, then wraps to 0. pix_tick is combinational: high when en=1 and divider==CLK_DIV-1. First pix_tick after reset release (en held high) occurs in cycle CLK_DIV.
- H counter: on pix_tick, increments. At H_TOTAL-1 it wraps to 0, and line_adv is asserted in the same clk.
- V counter: on pix_tick with line_adv, increments. At V_TOTAL-1 it wraps to 0. V changes only on line_adv.
- frame_start: combinational; equals pix_tick & (pixel_x==H_TOTAL-1) & (pixel_y==V_TOTAL-1), i.e. the clk on which the raster wraps to (0,0).
- Decoded outputs are registered from the current counter values and lag the counters by exactly one clk:
  - hsync=0 when H_VISIBLE+H_FP <= pixel_x <= H_VISIBLE+H_FP+H_SYNC-1 (656..751).
  - vsync=0 when V_VISIBLE+V_FP <= pixel_y <= V_VISIBLE+V_FP+V_SYNC-1 (490..491).
  - video_on=1 when pixel_x<H_VISIBLE and pixel_y<V_VISIBLE.
  - Consequence: video_on becomes 1 one clk after reset release.
- en=0: divider and counters hold; pix_tick, line_adv and frame_start are 0; decoded outputs keep tracking the held counters. On resuming en=1, the divider continues from its held value with no extra or lost tick.
- Reset mid-frame: all state returns to reset values on that edge. There is no partial-line completion.
- Comparisons are unsigned, at 10-bit width. Counter values are never outside 0..TOTAL-1.

Test Plan:
- Reset then en=1 for 10 clks -> pix_tick high exactly at clks 4 and 8. pixel_x=1 after clk 4 and 2 after clk 8. video_on=1 from clk 1.
- Run to pixel_x=799, pixel_y=0, then next pix_tick -> line_adv=1 in that clk. Afterwards pixel_x=0, pixel_y=1, frame_start=0.
- Run a full frame (800*525*4 = 1,680,000 clks) -> exactly one frame_start, at the (799,524)->(0,0) wrap. Exactly 525 line_adv pulses are counted.
- Line 0 -> hsync low exactly for pixel_x 656..751 (96 pixels, 384 clks). It is delayed one clk relative to the counter. video_on falls one clk after pixel_x reaches 640.
- Frame -> vsync low exactly while pixel_y is 490..491. video_on stays 0 for pixel_y 480..524.
- Drop en for 7 clks mid-line at divider=2, then restore -> counters frozen and no pulses while en=0. The next pix_tick arrives 1 clk after en returns.
- Assert rst at pixel_x=300, pixel_y=200 -> next edge gives counters 0,0, hsync=vsync=1, video_on=0. Normal sequence restarts.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA sequencer and its consumers
// (pixel generator, frame-update logic).
`timescale 1ns/1ps
interface vga_timing_if;
  logic       en;
  logic       pix_tick;
  logic       line_adv;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;

  modport master (
    input  en,
    output pix_tick, line_adv, frame_start, hsync, vsync, video_on, pixel_x, pixel_y
  );

  modport slave (
    output en,
    input  pix_tick, line_adv, frame_start, hsync, vsync, video_on, pixel_x, pixel_y
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster sequencer: pixel-rate divider, H/V counters and
// registered sync / video_on decode (one clk behind the counters).
`timescale 1ns/1ps
module vga_timing_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic             hs_q;
  logic             vs_q;
  logic             vo_q;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  always_comb begin
    tick   = vga.en && (div_q == DIV_LAST);
    h_wrap = (x_q == H_LAST);
    v_wrap = (y_q == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vo_q  <= 1'b0;
    end else begin
      if (vga.en) begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
      end
      if (tick) begin
        x_q <= h_wrap ? '0 : x_q + 10'd1;
        if (h_wrap) begin
          y_q <= v_wrap ? '0 : y_q + 10'd1;
        end
      end
      // Decode from the pre-update counters, so these trail pixel_x/y by one clk.
      hs_q <= !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
      vs_q <= !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
      vo_q <= (x_q < H_VIS) && (y_q < V_VIS);
    end
  end

  assign vga.pix_tick    = tick;
  assign vga.line_adv    = tick && h_wrap;
  assign vga.frame_start = tick && h_wrap && v_wrap;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = vo_q;

endmodule
